// File: rtl/cla_pipe_adder.sv
// Two-level carry-lookahead adder/subtractor with a 2-stage valid/ready pipeline.
// Stage 1 captures bit propagate/generate plus per-group lookahead terms;
// stage 2 resolves group carries, in-group carries and the registered result.
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             gg,
    output logic             pg
);

    localparam int NG = WIDTH / GROUP;
    localparam int IW = $clog2(WIDTH);

    // Lookahead carry out of bits [base +: len] given carry-in cin:
    // cin & P[all] | OR_j ( g[j] & P[j+1..top] ). len=0 returns cin.
    function automatic logic la_carry(input logic [WIDTH-1:0] gv,
                                      input logic [WIDTH-1:0] pv,
                                      input logic             cin,
                                      input int               base,
                                      input int               len);
        logic carry;
        logic term;
        carry = cin;
        for (int j = 0; j < len; j++) begin
            carry = carry & pv[IW'(base + j)];
        end
        for (int j = 0; j < len; j++) begin
            term = gv[IW'(base + j)];
            for (int m = j + 1; m < len; m++) begin
                term = term & pv[IW'(base + m)];
            end
            carry = carry | term;
        end
        return carry;
    endfunction

    // AND of the propagate bits [base +: len].
    function automatic logic la_prop(input logic [WIDTH-1:0] pv,
                                     input int               base,
                                     input int               len);
        logic prop;
        prop = 1'b1;
        for (int j = 0; j < len; j++) begin
            prop = prop & pv[IW'(base + j)];
        end
        return prop;
    endfunction

    // Stage 1 combinational terms
    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] g_s;
    logic             c0_s;
    logic [WIDTH-1:0] gg_grp_s;   // only [NG-1:0] used, upper bits stay 0
    logic [WIDTH-1:0] pg_grp_s;
    logic             pg_word_s;

    // Stage 1 registers
    logic             v1_q, v1_d;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] g_q;
    logic             c0_q;
    logic [WIDTH-1:0] gg_grp_q;
    logic [WIDTH-1:0] pg_grp_q;
    logic             pg_word_q;

    // Stage 2 combinational terms
    logic [WIDTH-1:0] grp_c_s;    // C[k] for k < NG
    logic [WIDTH-1:0] bit_c_s;    // carry into each bit
    logic [WIDTH-1:0] sum_s;
    logic             co_s;
    logic             ovf_s;
    logic             gg_word_s;

    // Stage 2 (output) registers
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             ovf_q;
    logic             gg_q;
    logic             pg_q;

    // Handshake
    logic             load1_s;
    logic             load2_s;

    // Operand conditioning, bit p/g and first-level group lookahead
    always_comb begin
        b_eff_s   = sub ? ~b : b;
        p_s       = a ^ b_eff_s;
        g_s       = a & b_eff_s;
        c0_s      = sub ? 1'b1 : ci;
        gg_grp_s  = '0;
        pg_grp_s  = '0;
        for (int k = 0; k < NG; k++) begin
            gg_grp_s[IW'(k)] = la_carry(g_s, p_s, 1'b0, k * GROUP, GROUP);
            pg_grp_s[IW'(k)] = la_prop(p_s, k * GROUP, GROUP);
        end
        pg_word_s = la_prop(p_s, 0, WIDTH);
    end

    // Second-level lookahead over groups, then in-group carries and sum
    always_comb begin
        grp_c_s = '0;
        bit_c_s = '0;
        for (int k = 0; k < NG; k++) begin
            grp_c_s[IW'(k)] = la_carry(gg_grp_q, pg_grp_q, c0_q, 0, k);
        end
        co_s      = la_carry(gg_grp_q, pg_grp_q, c0_q, 0, NG);
        gg_word_s = la_carry(gg_grp_q, pg_grp_q, 1'b0, 0, NG);
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < GROUP; j++) begin
                bit_c_s[IW'(k * GROUP + j)] =
                    la_carry(g_q, p_q, grp_c_s[IW'(k)], k * GROUP, j);
            end
        end
        sum_s = p_q ^ bit_c_s;
        ovf_s = bit_c_s[WIDTH-1] ^ co_s;
    end

    // Pipeline flow control: a stage loads when empty or when it drains downstream
    always_comb begin
        load2_s     = ~out_valid_q | out_ready;
        load1_s     = ~v1_q | load2_s;
        v1_d        = v1_q;
        out_valid_d = out_valid_q;
        if (load1_s) begin
            v1_d = in_valid;
        end else begin
            v1_d = v1_q;
        end
        if (load2_s) begin
            out_valid_d = v1_q;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    assign in_ready = load1_s;

    // Stage 1 register: captures operand-derived terms on input transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            p_q       <= '0;
            g_q       <= '0;
            c0_q      <= 1'b0;
            gg_grp_q  <= '0;
            pg_grp_q  <= '0;
            pg_word_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            if (load1_s && in_valid) begin
                p_q       <= p_s;
                g_q       <= g_s;
                c0_q      <= c0_s;
                gg_grp_q  <= gg_grp_s;
                pg_grp_q  <= pg_grp_s;
                pg_word_q <= pg_word_s;
            end
        end
    end

    // Stage 2 register: result held stable while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            gg_q        <= 1'b0;
            pg_q        <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (load2_s && v1_q) begin
                s_q   <= sum_s;
                co_q  <= co_s;
                ovf_q <= ovf_s;
                gg_q  <= gg_word_s;
                pg_q  <= pg_word_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign co        = co_q;
    assign ovf       = ovf_q;
    assign gg        = gg_q;
    assign pg        = pg_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder: 32-bit/4-bit-group and 16-bit/8-bit-group instances.
module tb_cla_pipe_adder;

    logic clk = 1'b0;
    logic rst_n;

    // 32-bit instance
    logic        in_valid, in_ready, ci, sub, out_valid, out_ready;
    logic [31:0] a, b, s;
    logic        co, ovf, gg, pg;

    // 16-bit instance
    logic        in_valid16, in_ready16, ci16, sub16, out_valid16, out_ready16;
    logic [15:0] a16, b16, s16;
    logic        co16, ovf16, gg16, pg16;

    int checks = 0;
    int errors = 0;

    logic [35:0] exp_mem [100];
    logic [35:0] xe [3];
    logic [31:0] ra, rb;
    logic        rc, rs;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(32), .GROUP(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .co(co), .ovf(ovf), .gg(gg), .pg(pg)
    );

    cla_pipe_adder #(.WIDTH(16), .GROUP(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .ci(ci16), .sub(sub16), .out_valid(out_valid16),
        .out_ready(out_ready16), .s(s16), .co(co16), .ovf(ovf16), .gg(gg16), .pg(pg16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {gg, pg, ovf, co, s} from plain arithmetic
    function automatic logic [35:0] ref32(input logic [31:0] av, input logic [31:0] bv,
                                          input logic civ, input logic subv);
        logic [31:0] bb;
        logic [32:0] sum;
        logic [32:0] nc;
        logic        c0;
        logic        ov;
        bb  = subv ? ~bv : bv;
        c0  = subv ? 1'b1 : civ;
        sum = {1'b0, av} + {1'b0, bb} + {32'd0, c0};
        nc  = {1'b0, av} + {1'b0, bb};
        ov  = (av[31] == bb[31]) && (sum[31] != av[31]);
        return {nc[32], &(av ^ bb), ov, sum[32], sum[31:0]};
    endfunction

    function automatic logic [63:0] obs32();
        return 64'({gg, pg, ovf, co, s});
    endfunction

    function automatic logic [63:0] obs16();
        return 64'({gg16, pg16, ovf16, co16, s16});
    endfunction

    task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv,
                         input logic civ, input logic subv);
        in_valid = v;
        a        = av;
        b        = bv;
        ci       = civ;
        sub      = subv;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        out_ready   = 1'b1;
        in_valid16  = 1'b0;
        a16         = 16'd0;
        b16         = 16'd0;
        ci16        = 1'b0;
        sub16       = 1'b0;
        out_ready16 = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", obs32(), 64'd0);
        check("rst_out_valid16", 64'(out_valid16), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Test 1: all-ones + 0 + ci ripples carry through every group
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("t1_latency", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_result", obs32(), 64'({1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000}));
        @(negedge clk);
        check("t1_bubble", 64'(out_valid), 64'd0);
        check("t1_hold", obs32(), 64'({1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000}));

        // Test 2: signed overflow, then subtraction with borrow
        drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("t2_ovf_valid", 64'(out_valid), 64'd1);
        check("t2_ovf_result", obs32(), 64'({1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0000}));
        @(negedge clk);
        check("t2_sub_valid", 64'(out_valid), 64'd1);
        check("t2_sub_result", obs32(), 64'({1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE}));
        @(negedge clk);

        // Test 3: 100 back-to-back random ops, one result per cycle at latency 2
        for (int cyc = 0; cyc <= 100; cyc++) begin
            if (cyc < 100) begin
                ra = $urandom;
                rb = $urandom;
                rc = 1'($urandom_range(0, 1));
                rs = 1'($urandom_range(0, 1));
                exp_mem[cyc] = ref32(ra, rb, rc, rs);
                drive(1'b1, ra, rb, rc, rs);
                check("t3_in_ready", 64'(in_ready), 64'd1);
            end else begin
                drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            end
            @(negedge clk);
            if (cyc >= 1) begin
                check("t3_valid", 64'(out_valid), 64'd1);
                check("t3_result", obs32(), 64'(exp_mem[cyc-1]));
            end
        end
        @(negedge clk);
        check("t3_drained", 64'(out_valid), 64'd0);

        // Test 4: output stall with continuous input
        xe[0] = ref32(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        xe[1] = ref32(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0);
        xe[2] = ref32(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        out_ready = 1'b0;
        drive(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        check("t4_ready_accept0", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive(1'b1, 32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0);
        check("t4_ready_accept1", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        check("t4_ready_drop", 64'(in_ready), 64'd0);
        check("t4_full_valid", 64'(out_valid), 64'd1);
        check("t4_full_result", obs32(), 64'(xe[0]));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_stall_ready", 64'(in_ready), 64'd0);
            check("t4_stall_valid", 64'(out_valid), 64'd1);
            check("t4_stall_result", obs32(), 64'(xe[0]));
        end
        out_ready = 1'b1;
        #1;
        check("t4_ready_release", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("t4_order1_valid", 64'(out_valid), 64'd1);
        check("t4_order1_result", obs32(), 64'(xe[1]));
        @(negedge clk);
        check("t4_order2_valid", 64'(out_valid), 64'd1);
        check("t4_order2_result", obs32(), 64'(xe[2]));
        @(negedge clk);
        check("t4_empty", 64'(out_valid), 64'd0);

        // Test 5: asynchronous reset with both stages full
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("t5_full_valid", 64'(out_valid), 64'd1);
        check("t5_full_result", obs32(), 64'(ref32(32'h3, 32'h4, 1'b0, 1'b0)));
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_outputs", obs32(), 64'd0);
        check("t5_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_stale", 64'(out_valid), 64'd0);
        end

        // Test 6: WIDTH=16, GROUP=8 carries crossing the group boundary
        in_valid16 = 1'b1;
        a16        = 16'h00FF;
        b16        = 16'h0001;
        @(negedge clk);
        a16        = 16'hFF00;
        b16        = 16'h0100;
        @(negedge clk);
        in_valid16 = 1'b0;
        check("t6_a_valid", 64'(out_valid16), 64'd1);
        check("t6_a_result", obs16(), 64'h0_0100);
        @(negedge clk);
        check("t6_b_valid", 64'(out_valid16), 64'd1);
        check("t6_b_result", obs16(), 64'h9_0000);
        @(negedge clk);
        check("t6_empty", 64'(out_valid16), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
